// File: rtl/dm_arbiter.sv
// Two-requester arbiter in front of the single-port, synchronous-read data RAM (cpu vs debug port).
// Default build: fixed cpu priority with a dbg starvation guard; define DM_ARB_RR_EN for round-robin contention.
module dm_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic [31:0] dbg_addr,
    input  logic [3:0]  dbg_wen,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DBG
    } owner_t;

    owner_t rd_owner;
    logic   dbg_wins;

`ifdef DM_ARB_RR_EN
    // last_winner: 1 means dbg took the most recent contended grant.
    logic last_winner;

    always_comb begin
        dbg_wins = dbg_req && (!cpu_req || !last_winner);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= 1'b1;
        end else if (cpu_req && dbg_req) begin
            last_winner <= dbg_wins;
        end
    end
`else
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        dbg_wins = dbg_req && (!cpu_req || (starve_cnt == STARVE_LIM));
    end

    // Counts consecutive denied dbg cycles, holding at the limit until dbg is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (dbg_req && !dbg_gnt) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else begin
            starve_cnt <= '0;
        end
    end
`endif

    always_comb begin
        dbg_gnt = !reset && dbg_wins;
        cpu_gnt = !reset && cpu_req && !dbg_wins;
    end

    always_comb begin
        ram_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
        ram_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
        if (cpu_gnt) begin
            ram_wen = cpu_wen;
        end else if (dbg_gnt) begin
            ram_wen = dbg_wen;
        end else begin
            ram_wen = 4'b0000;
        end
    end

    // Remembers who issued last cycle's read so the returning data is steered to them.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_owner <= OWN_NONE;
        end else if (cpu_gnt && (cpu_wen == 4'b0000)) begin
            rd_owner <= OWN_CPU;
        end else if (dbg_gnt && (dbg_wen == 4'b0000)) begin
            rd_owner <= OWN_DBG;
        end else begin
            rd_owner <= OWN_NONE;
        end
    end

    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign dbg_rvalid = (rd_owner == OWN_DBG);
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized plus directed self-checking bench for dm_arbiter against a cycle-level reference model.
`timescale 1ns/1ps
module tb_dm_arbiter;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, dbg_req;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, ram_rdata;
    logic [3:0]  cpu_wen, dbg_wen;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata;
    logic [3:0]  ram_wen;

    int checks = 0;
    int errors = 0;

    // Reference model state: owner of the read issued last cycle (0 none, 1 cpu, 2 dbg)
    int m_owner = 0;
    int m_starve = 0;
    int m_last_dbg = 1;

    // Values seen during the most recent applied cycle
    logic        obs_cpu_gnt, obs_dbg_gnt, obs_cpu_rvalid, obs_dbg_rvalid;
    logic [3:0]  obs_ram_wen;
    logic [31:0] obs_cpu_rdata, obs_dbg_rdata;

    dm_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wen(cpu_wen), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_wen(dbg_wen), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, checks the DUT against the model, then advances the model past the edge.
    task automatic applyStimulus(
        input logic rst,
        input logic creq, input logic [31:0] caddr, input logic [3:0] cwen, input logic [31:0] cwdata,
        input logic dreq, input logic [31:0] daddr, input logic [3:0] dwen, input logic [31:0] dwdata,
        input logic [31:0] rdata);
        int winner;
        logic [3:0]  e_wen;
        logic [31:0] e_addr, e_wdata;
        reset = rst;
        cpu_req = creq; cpu_addr = caddr; cpu_wen = cwen; cpu_wdata = cwdata;
        dbg_req = dreq; dbg_addr = daddr; dbg_wen = dwen; dbg_wdata = dwdata;
        ram_rdata = rdata;
        #1;
        winner = 0;
        if (!rst) begin
            if (creq && dreq) begin
`ifdef DM_ARB_RR_EN
                winner = (m_last_dbg != 0) ? 1 : 2;
`else
                winner = (m_starve >= STARVE_MAX) ? 2 : 1;
`endif
            end else if (creq) begin
                winner = 1;
            end else if (dreq) begin
                winner = 2;
            end
        end
        e_addr  = (winner == 2) ? daddr  : caddr;
        e_wdata = (winner == 2) ? dwdata : cwdata;
        e_wen   = (winner == 1) ? cwen : (winner == 2) ? dwen : 4'b0000;

        obs_cpu_gnt = cpu_gnt; obs_dbg_gnt = dbg_gnt; obs_ram_wen = ram_wen;
        obs_cpu_rvalid = cpu_rvalid; obs_dbg_rvalid = dbg_rvalid;
        obs_cpu_rdata = cpu_rdata; obs_dbg_rdata = dbg_rdata;

        checkOutput("cpu_gnt", {31'd0, cpu_gnt}, {31'd0, winner == 1});
        checkOutput("dbg_gnt", {31'd0, dbg_gnt}, {31'd0, winner == 2});
        checkOutput("ram_wen", {28'd0, ram_wen}, {28'd0, e_wen});
        checkOutput("ram_addr", ram_addr, e_addr);
        checkOutput("ram_wdata", ram_wdata, e_wdata);
        checkOutput("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, m_owner == 1});
        checkOutput("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m_owner == 2});
        if (m_owner == 1) checkOutput("cpu_rdata", cpu_rdata, rdata);
        if (m_owner == 2) checkOutput("dbg_rdata", dbg_rdata, rdata);

        @(posedge clk);
        if (rst) begin
            m_owner = 0; m_starve = 0; m_last_dbg = 1;
        end else begin
            if (winner == 1 && cwen == 4'b0000)      m_owner = 1;
            else if (winner == 2 && dwen == 4'b0000) m_owner = 2;
            else                                     m_owner = 0;
            if (dreq && winner != 2) m_starve = (m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1;
            else                     m_starve = 0;
            if (creq && dreq) m_last_dbg = (winner == 2) ? 1 : 0;
        end
        #1;
    endtask

    task automatic idleCycle(input logic rst, input logic [31:0] rdata);
        applyStimulus(rst, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, rdata);
    endtask

    initial begin
        logic        c_req, d_req;
        logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
        logic [3:0]  c_wen, d_wen;
        logic        c_hold, d_hold;

        reset = 1'b1;
        cpu_req = 1'b0; dbg_req = 1'b0;
        cpu_addr = '0; cpu_wen = '0; cpu_wdata = '0;
        dbg_addr = '0; dbg_wen = '0; dbg_wdata = '0; ram_rdata = '0;
        @(posedge clk); #1;

        // Reset: grants and write enable held low even with both requesting writes
        applyStimulus(1'b1, 1'b1, 32'h40, 4'hF, 32'h1, 1'b1, 32'h44, 4'hF, 32'h2, 32'h0);
        checkOutput("reset_gnt", {30'd0, obs_cpu_gnt, obs_dbg_gnt}, 32'd0);
        checkOutput("reset_wen", {28'd0, obs_ram_wen}, 32'd0);
        idleCycle(1'b0, 32'h0);

        // cpu read then data return
        applyStimulus(1'b0, 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("rd_gnt", {31'd0, obs_cpu_gnt}, 32'd1);
        idleCycle(1'b0, 32'hDEADBEEF);
        checkOutput("rd_rvalid", {31'd0, obs_cpu_rvalid}, 32'd1);
        checkOutput("rd_data", obs_cpu_rdata, 32'hDEADBEEF);
        checkOutput("rd_dbg_rvalid", {31'd0, obs_dbg_rvalid}, 32'd0);

        // cpu byte write produces no rvalid
        applyStimulus(1'b0, 1'b1, 32'h20, 4'b0100, 32'h00AB0000, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("wr_wen", {28'd0, obs_ram_wen}, 32'h4);
        idleCycle(1'b0, 32'h12345678);
        checkOutput("wr_no_rvalid", {31'd0, obs_cpu_rvalid}, 32'd0);

        // Continuous contention from a clean reset
        idleCycle(1'b1, 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 32'h100, 4'h0, 32'h0, 1'b1, 32'h200, 4'h0, 32'h0, 32'hA000 + i);
`ifdef DM_ARB_RR_EN
            checkOutput("contend_dbg_gnt", {31'd0, obs_dbg_gnt}, {31'd0, (i % 2) == 1});
            checkOutput("contend_dbg_rvalid", {31'd0, obs_dbg_rvalid}, {31'd0, i > 0 && (i % 2) == 0});
`else
            checkOutput("contend_dbg_gnt", {31'd0, obs_dbg_gnt}, {31'd0, i == 4});
            checkOutput("contend_dbg_rvalid", {31'd0, obs_dbg_rvalid}, {31'd0, i == 5});
`endif
        end
        idleCycle(1'b1, 32'h0);

        // Back-to-back cpu reads
        applyStimulus(1'b0, 1'b1, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h4, 4'h0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h11111111);
        checkOutput("b2b_first", obs_cpu_rvalid ? obs_cpu_rdata : 32'hFFFFFFFF, 32'h11111111);
        idleCycle(1'b0, 32'h22222222);
        checkOutput("b2b_second", obs_cpu_rvalid ? obs_cpu_rdata : 32'hFFFFFFFF, 32'h22222222);

        // dbg read interrupted by reset
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h80, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h84, 4'hF, 32'h5, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        checkOutput("rst_mid_gnt", {30'd0, obs_cpu_gnt, obs_dbg_gnt}, 32'd0);
        checkOutput("rst_mid_wen", {28'd0, obs_ram_wen}, 32'd0);
        idleCycle(1'b0, 32'h0);
        checkOutput("rst_mid_rvalid", {31'd0, obs_dbg_rvalid}, 32'd0);

        // Random traffic honouring the hold-until-grant rule, occasionally withdrawing or resetting
        c_req = 1'b0; d_req = 1'b0; c_hold = 1'b0; d_hold = 1'b0;
        c_addr = '0; c_wen = '0; c_wdata = '0; d_addr = '0; d_wen = '0; d_wdata = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(c_hold && $urandom_range(0, 7) != 0)) begin
                c_req = ($urandom_range(0, 3) != 0);
                c_addr = $urandom; c_wdata = $urandom;
                c_wen = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            end
            if (!(d_hold && $urandom_range(0, 7) != 0)) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_addr = $urandom; d_wdata = $urandom;
                d_wen = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom);
            end
            applyStimulus(($urandom_range(0, 49) == 0), c_req, c_addr, c_wen, c_wdata,
                          d_req, d_addr, d_wen, d_wdata, $urandom);
            c_hold = c_req && !obs_cpu_gnt;
            d_hold = d_req && !obs_dbg_gnt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
